udp_port_demux: RTL
===================

# udp_port_demux

Receive-side UDP dispatcher placed after the UDP RX path and ahead of application endpoints. Accepts one UDP header and payload stream, matches the destination port against a run-time table of `CHANNELS` entries, and steers the frame to the matching output channel. Frames that match no entry are consumed and dropped. Forwarded and dropped frames are counted. It is the parametrised successor of the single-endpoint UDP interface: channel count and data width are generic, and the payload stream carries `tkeep`.

## Interface
- `CHANNELS`, 4: number of output channels (1..16)
- `DATA_WIDTH`, 8: payload bus width, a multiple of 8
- `KEEP_WIDTH`, `DATA_WIDTH/8`: byte-enable width
- `clk`  in  1  clock; all logic is on the rising edge
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `s_udp_hdr_valid` / `s_udp_hdr_ready`  in/out  1  header handshake
- `s_ip_source_ip`, `s_ip_dest_ip`  in  32  IP addresses
- `s_udp_source_port`, `s_udp_dest_port`, `s_udp_length`, `s_udp_checksum`  in  16  UDP header fields
- `s_udp_payload_axis_tdata`  in  `DATA_WIDTH`  payload data
- `s_udp_payload_axis_tkeep`  in  `KEEP_WIDTH`  payload byte enables
- `s_udp_payload_axis_tvalid`, `tready` (out), `tlast`, `tuser`  in  1  payload handshake and flags
- `cfg_port`  in  `16*CHANNELS`  destination port per channel; channel i is at bits [16i+15:16i]
- `cfg_enable`  in  `CHANNELS`  per-channel match enable
- `m_udp_hdr_valid`  out  `CHANNELS`  one-hot header valid
- `m_udp_hdr_ready`  in  `CHANNELS`  per-channel header ready
- `m_ip_source_ip`, `m_ip_dest_ip`, `m_udp_*` header fields  out  32/16  registered header, shared by all channels
- `m_udp_payload_axis_tvalid`  out  `CHANNELS`  one-hot payload valid
- `m_udp_payload_axis_tready`  in  `CHANNELS`  per-channel payload ready
- `m_udp_payload_axis_tdata`, `tkeep`, `tlast`, `tuser`  out  shared payload bus
- `busy`  out  1  asserted in any state other than IDLE
- `fwd_count`, `drop_count`  out  32  saturating frame counters

## Operation
- The block has four states: IDLE, HDR, PAYLOAD, DROP.
- IDLE
  - `s_udp_hdr_ready` = 1.
  - On a header handshake, the block latches all header fields and computes the selected channel as the lowest index i with `cfg_enable[i]` set and `cfg_port[i] == s_udp_dest_port`.
  - On a match, the selected channel is registered and the state moves to HDR. With no match, the state moves to DROP.
- HDR
  - `m_udp_hdr_valid[sel]` = 1.
  - When `m_udp_hdr_ready[sel]` is seen, the state moves to PAYLOAD.
- PAYLOAD
  - `m_udp_payload_axis_tvalid[sel]` = `s_tvalid`.
  - `s_tready` = `m_tready[sel]`.
  - data, keep, last and user pass through combinationally.
  - On the handshake of the `tlast` beat: `fwd_count`++ and the state moves to IDLE.
- DROP
  - `s_tready` = 1 and no output valid is asserted.
  - On the `tlast` beat: `drop_count`++ and the state moves to IDLE.
- `cfg_port` and `cfg_enable` are sampled only at the header handshake. Changes during a frame do not affect that frame.
- If ports are duplicated across enabled entries, the lowest index wins.
- Frames with `tuser` = 1 are forwarded unchanged; error policy belongs downstream. `tkeep` is not interpreted.
- Both counters saturate at 0xFFFFFFFF and do not wrap.

## Timing
- Reset values:
  - state IDLE, so `s_udp_hdr_ready` = 1 and `busy` = 0.
  - all `m_*_valid` = 0.
  - header registers = 0.
  - both counters = 0.
  - `s_udp_payload_axis_tready` = 0.
- Header handshake at cycle T gives `m_udp_hdr_valid` at T+1.
- The earliest payload forwarding is at T+2 if the downstream header ready is already high at T+1.
- Payload latency is 0 cycles: a pure combinational pass in PAYLOAD.
- A back-to-back next header is accepted no earlier than the cycle after the `tlast` handshake.
- Payload beats that arrive before the frame reaches PAYLOAD or DROP are stalled (`tready` = 0), never lost.
- A single-beat frame (`tlast` on the first beat) is legal in both PAYLOAD and DROP.
- An asynchronous `rst_n` assertion mid-frame:
  - immediately returns the block to IDLE and clears valids and counters.
  - The partial frame is abandoned; the upstream is responsible for flushing it.
- A counter increment at the saturation value holds at 0xFFFFFFFF.

## Structure
- Package `udp_demux_pkg`:
  - state enum (IDLE, HDR, PAYLOAD, DROP).
  - `UDP_PORT_W` = 16.
  - `MAX_CHANNELS` = 16.
- Sub-module `udp_port_match`:
  - purely combinational priority match of `dest_port` against `cfg_port` and `cfg_enable`.
  - outputs `hit` and a channel index of width `$clog2(CHANNELS)`, with a minimum width of 1.
- The top level holds the FSM, the header registers, the one-hot fan-out and the counters.

## Test plan
- `CHANNELS` = 4, `cfg_port` = {53, 80, 443, 51820}, all enabled; a frame to port 51820 with 3 beats -> only `m_*_valid[3]` toggles, data intact, `fwd_count` = 1.
- Frame to port 9999 with 5 beats -> `s_tready` held at 1, no output valid, `drop_count` = 1, `fwd_count` unchanged.
- `cfg_port[1]` = `cfg_port[2]` = 80, both enabled; frame to 80 -> channel 1. Then disable channel 1; the next frame goes to channel 2.
- `m_tready[0]` toggles randomly and `cfg_port[0]` changes mid-frame -> no lost or duplicated beats, and the frame stays on channel 0.
- `rst_n` pulsed low during PAYLOAD beat 2 -> all valids 0 and counters 0 immediately. After release, `s_udp_hdr_ready` = 1 and the next frame forwards correctly.
- Preload `drop_count` near saturation via 0xFFFFFFFF dropped frames, or force it in the bench -> stays at 0xFFFFFFFF.

Source files
------------

// File: rtl/udp_demux_pkg.sv
// Shared types and constants for the UDP destination-port demultiplexer.
package udp_demux_pkg;

    localparam int unsigned UDP_PORT_W   = 16;
    localparam int unsigned MAX_CHANNELS = 16;

    typedef enum logic [1:0] {StIdle, StHdr, StPayload, StDrop} demux_state_e;

    typedef struct packed {
        logic [31:0]           source_ip;
        logic [31:0]           dest_ip;
        logic [UDP_PORT_W-1:0] source_port;
        logic [UDP_PORT_W-1:0] dest_port;
        logic [15:0]           length;
        logic [15:0]           checksum;
    } udp_hdr_t;

    // Frame counters stick at all-ones rather than wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/udp_port_match.sv
// Combinational priority match of a UDP destination port against the channel table.
module udp_port_match
    import udp_demux_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic [UDP_PORT_W-1:0]          dest_port,
    input  logic [UDP_PORT_W*CHANNELS-1:0] cfg_port,
    input  logic [CHANNELS-1:0]            cfg_enable,
    output logic                           hit,
    output logic [IDX_W-1:0]               idx
);

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (cfg_enable[i] && (cfg_port[i*UDP_PORT_W +: UDP_PORT_W] == dest_port)) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/udp_port_demux.sv
// Steers one UDP header+payload stream to the channel whose configured port matches,
// dropping unmatched frames and counting forwarded and dropped frames.
module udp_port_demux
    import udp_demux_pkg::*;
#(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_udp_hdr_valid,
    output logic                           s_udp_hdr_ready,
    input  logic [31:0]                    s_ip_source_ip,
    input  logic [31:0]                    s_ip_dest_ip,
    input  logic [15:0]                    s_udp_source_port,
    input  logic [15:0]                    s_udp_dest_port,
    input  logic [15:0]                    s_udp_length,
    input  logic [15:0]                    s_udp_checksum,
    input  logic [DATA_WIDTH-1:0]          s_udp_payload_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]          s_udp_payload_axis_tkeep,
    input  logic                           s_udp_payload_axis_tvalid,
    output logic                           s_udp_payload_axis_tready,
    input  logic                           s_udp_payload_axis_tlast,
    input  logic                           s_udp_payload_axis_tuser,
    input  logic [UDP_PORT_W*CHANNELS-1:0] cfg_port,
    input  logic [CHANNELS-1:0]            cfg_enable,
    output logic [CHANNELS-1:0]            m_udp_hdr_valid,
    input  logic [CHANNELS-1:0]            m_udp_hdr_ready,
    output logic [31:0]                    m_ip_source_ip,
    output logic [31:0]                    m_ip_dest_ip,
    output logic [15:0]                    m_udp_source_port,
    output logic [15:0]                    m_udp_dest_port,
    output logic [15:0]                    m_udp_length,
    output logic [15:0]                    m_udp_checksum,
    output logic [CHANNELS-1:0]            m_udp_payload_axis_tvalid,
    input  logic [CHANNELS-1:0]            m_udp_payload_axis_tready,
    output logic [DATA_WIDTH-1:0]          m_udp_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0]          m_udp_payload_axis_tkeep,
    output logic                           m_udp_payload_axis_tlast,
    output logic                           m_udp_payload_axis_tuser,
    output logic                           busy,
    output logic [31:0]                    fwd_count,
    output logic [31:0]                    drop_count
);

    localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    demux_state_e        state_q;
    logic [IDX_W-1:0]    sel_q;
    logic [CHANNELS-1:0] hdr_valid_q;
    udp_hdr_t            hdr_q;
    logic [31:0]         fwd_count_q;
    logic [31:0]         drop_count_q;

    logic             match_hit;
    logic [IDX_W-1:0] match_idx;
    logic             tlast_hs;

    udp_port_match #(
        .CHANNELS (CHANNELS),
        .IDX_W    (IDX_W)
    ) u_match (
        .dest_port  (s_udp_dest_port),
        .cfg_port   (cfg_port),
        .cfg_enable (cfg_enable),
        .hit        (match_hit),
        .idx        (match_idx)
    );

    assign tlast_hs = s_udp_payload_axis_tvalid && s_udp_payload_axis_tready &&
                      s_udp_payload_axis_tlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            sel_q        <= '0;
            hdr_valid_q  <= '0;
            hdr_q        <= '0;
            fwd_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (s_udp_hdr_valid) begin
                        hdr_q <= '{source_ip:   s_ip_source_ip,
                                   dest_ip:     s_ip_dest_ip,
                                   source_port: s_udp_source_port,
                                   dest_port:   s_udp_dest_port,
                                   length:      s_udp_length,
                                   checksum:    s_udp_checksum};
                        if (match_hit) begin
                            sel_q       <= match_idx;
                            hdr_valid_q <= CHANNELS'(1) << match_idx;
                            state_q     <= StHdr;
                        end else begin
                            state_q <= StDrop;
                        end
                    end
                end
                StHdr: begin
                    if (m_udp_hdr_ready[sel_q]) begin
                        hdr_valid_q <= '0;
                        state_q     <= StPayload;
                    end
                end
                StPayload: begin
                    if (tlast_hs) begin
                        fwd_count_q <= sat_inc(fwd_count_q);
                        state_q     <= StIdle;
                    end
                end
                StDrop: begin
                    if (tlast_hs) begin
                        drop_count_q <= sat_inc(drop_count_q);
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Payload path is a zero-latency pass; only the selected lane sees valid.
    always_comb begin
        m_udp_payload_axis_tvalid = '0;
        s_udp_payload_axis_tready = 1'b0;
        case (state_q)
            StPayload: begin
                m_udp_payload_axis_tvalid[sel_q] = s_udp_payload_axis_tvalid;
                s_udp_payload_axis_tready        = m_udp_payload_axis_tready[sel_q];
            end
            StDrop:  s_udp_payload_axis_tready = 1'b1;
            default: ;
        endcase
    end

    assign s_udp_hdr_ready          = (state_q == StIdle);
    assign busy                     = (state_q != StIdle);
    assign m_udp_hdr_valid          = hdr_valid_q;
    assign m_ip_source_ip           = hdr_q.source_ip;
    assign m_ip_dest_ip             = hdr_q.dest_ip;
    assign m_udp_source_port        = hdr_q.source_port;
    assign m_udp_dest_port          = hdr_q.dest_port;
    assign m_udp_length             = hdr_q.length;
    assign m_udp_checksum           = hdr_q.checksum;
    assign m_udp_payload_axis_tdata = s_udp_payload_axis_tdata;
    assign m_udp_payload_axis_tkeep = s_udp_payload_axis_tkeep;
    assign m_udp_payload_axis_tlast = s_udp_payload_axis_tlast;
    assign m_udp_payload_axis_tuser = s_udp_payload_axis_tuser;
    assign fwd_count                = fwd_count_q;
    assign drop_count               = drop_count_q;

endmodule
